// File: rtl/adc_spi_responder.sv
// ============================================================================
//  Module   : adc_spi_responder
//  Purpose  : SPI mode-0 slave that emulates an 8-channel, 12-bit serial ADC.
//             Each 16-SCLK frame returns 4 leading zeros plus the 12-bit
//             sample selected by the channel address sent in the previous
//             frame. Sample registers are loaded through a simple write strobe.
//             SCLK, CS_N and MOSI are oversampled in the i_Clk domain.
//  Ports    : i_Clk, i_Rst_L         system clock, synchronous active-low reset
//             i_SPI_Clk/CS_n/MOSI    SPI master pins (asynchronous)
//             o_SPI_MISO             conversion data, always driven
//             i_Wr_DV/Chan/Data      sample register write port
//             o_Cur_Chan             channel being shifted out this frame
//             o_Next_Chan            channel committed for the next frame
//             o_Frame_DV             one-cycle pulse on frame completion
//             o_Busy                 high while a frame is in progress
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module adc_spi_responder #(
    parameter int DATA_WIDTH = 12,
    parameter int FRAME_BITS = 16,
    parameter int NUM_CHAN   = 8
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst_L,
    input  logic                  i_SPI_Clk,
    input  logic                  i_SPI_CS_n,
    input  logic                  i_SPI_MOSI,
    output logic                  o_SPI_MISO,
    input  logic                  i_Wr_DV,
    input  logic [2:0]            i_Wr_Chan,
    input  logic [DATA_WIDTH-1:0] i_Wr_Data,
    output logic [2:0]            o_Cur_Chan,
    output logic [2:0]            o_Next_Chan,
    output logic                  o_Frame_DV,
    output logic                  o_Busy
);

    localparam int CHAN_W = 3;
    localparam int CNT_W  = $clog2(FRAME_BITS + 1);
    localparam int PAD_W  = FRAME_BITS - DATA_WIDTH;
    // Position, before the final shift, of the bit captured on rise 3 (ADD2).
    localparam int ADDR_MSB = FRAME_BITS - 4;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_BITS - 1);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LOAD      = 2'd1,
        ST_SHIFT     = 2'd2,
        ST_WAIT_FALL = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Pin synchronizers and edge detectors
    // ------------------------------------------------------------------
    logic r_sclk_meta_q, r_sclk_sync_q, r_sclk_prev_q;
    logic r_cs_meta_q,   r_cs_sync_q,   r_cs_prev_q;
    logic r_mosi_meta_q, r_mosi_sync_q, r_mosi_prev_q;

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            r_sclk_meta_q <= 1'b0;
            r_sclk_sync_q <= 1'b0;
            r_sclk_prev_q <= 1'b0;
            // CS idles high so a reset never fabricates a select edge.
            r_cs_meta_q   <= 1'b1;
            r_cs_sync_q   <= 1'b1;
            r_cs_prev_q   <= 1'b1;
            r_mosi_meta_q <= 1'b0;
            r_mosi_sync_q <= 1'b0;
            r_mosi_prev_q <= 1'b0;
        end else begin
            r_sclk_meta_q <= i_SPI_Clk;
            r_sclk_sync_q <= r_sclk_meta_q;
            r_sclk_prev_q <= r_sclk_sync_q;
            r_cs_meta_q   <= i_SPI_CS_n;
            r_cs_sync_q   <= r_cs_meta_q;
            r_cs_prev_q   <= r_cs_sync_q;
            r_mosi_meta_q <= i_SPI_MOSI;
            r_mosi_sync_q <= r_mosi_meta_q;
            r_mosi_prev_q <= r_mosi_sync_q;
        end
    end

    logic w_sclk_rise, w_sclk_fall, w_cs_fall, w_cs_rise;

    // SCLK activity only counts while the device is selected.
    assign w_sclk_rise = r_sclk_sync_q & ~r_sclk_prev_q & ~r_cs_sync_q;
    assign w_sclk_fall = ~r_sclk_sync_q & r_sclk_prev_q & ~r_cs_sync_q;
    assign w_cs_fall   = ~r_cs_sync_q & r_cs_prev_q;
    assign w_cs_rise   = r_cs_sync_q & ~r_cs_prev_q;

    // ------------------------------------------------------------------
    // Sample registers
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] r_sample_q [NUM_CHAN];
    logic [DATA_WIDTH-1:0] w_sample_d [NUM_CHAN];

    always_comb begin
        w_sample_d = r_sample_q;
        if (i_Wr_DV) begin
            w_sample_d[i_Wr_Chan] = i_Wr_Data;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            for (int i = 0; i < NUM_CHAN; i++) begin
                r_sample_q[i] <= '0;
            end
        end else begin
            r_sample_q <= w_sample_d;
        end
    end

    // ------------------------------------------------------------------
    // Frame state machine
    // ------------------------------------------------------------------
    state_t                r_state_q,     w_state_d;
    logic [CNT_W-1:0]      r_cnt_q,       w_cnt_d;
    logic [FRAME_BITS-1:0] r_rx_q,        w_rx_d;
    logic [FRAME_BITS-1:0] r_tx_q,        w_tx_d;
    logic                  r_miso_q,      w_miso_d;
    logic [CHAN_W-1:0]     r_cur_chan_q,  w_cur_chan_d;
    logic [CHAN_W-1:0]     r_next_chan_q, w_next_chan_d;
    logic                  r_frame_dv_q,  w_frame_dv_d;

    logic [FRAME_BITS-1:0] w_tx_load;

    // Reads the pre-write register value, so a write landing on the load
    // cycle only shows up from the following frame.
    assign w_tx_load = {{PAD_W{1'b0}}, r_sample_q[r_next_chan_q]};

    always_comb begin
        w_state_d     = r_state_q;
        w_cnt_d       = r_cnt_q;
        w_rx_d        = r_rx_q;
        w_tx_d        = r_tx_q;
        w_miso_d      = r_miso_q;
        w_cur_chan_d  = r_cur_chan_q;
        w_next_chan_d = r_next_chan_q;
        w_frame_dv_d  = 1'b0;

        case (r_state_q)
            ST_IDLE: begin
                w_miso_d = 1'b0;
                w_cnt_d  = '0;
                if (w_cs_fall) begin
                    w_state_d = ST_LOAD;
                end
            end

            ST_LOAD: begin
                w_tx_d       = w_tx_load;
                w_cur_chan_d = r_next_chan_q;
                w_miso_d     = w_tx_load[FRAME_BITS-1];
                w_cnt_d      = '0;
                w_state_d    = ST_SHIFT;
            end

            ST_SHIFT: begin
                if (w_sclk_rise) begin
                    w_rx_d = {r_rx_q[FRAME_BITS-2:0], r_mosi_prev_q};
                    if (r_cnt_q == CNT_LAST) begin
                        // The rise-3..5 bits sit one place lower before
                        // the final shift, so take them from r_rx_q.
                        w_next_chan_d = r_rx_q[ADDR_MSB -: CHAN_W];
                        w_frame_dv_d  = 1'b1;
                        w_cnt_d       = '0;
                        w_state_d     = ST_WAIT_FALL;
                    end else begin
                        w_cnt_d = r_cnt_q + CNT_W'(1);
                    end
                end else if (w_sclk_fall && (r_cnt_q != '0)) begin
                    w_tx_d   = {r_tx_q[FRAME_BITS-2:0], 1'b0};
                    w_miso_d = r_tx_q[FRAME_BITS-2];
                end
            end

            ST_WAIT_FALL: begin
                // Closing fall of a frame doubles as the load for the next
                // one, so CS may stay low indefinitely.
                if (w_sclk_fall) begin
                    w_tx_d       = w_tx_load;
                    w_cur_chan_d = r_next_chan_q;
                    w_miso_d     = w_tx_load[FRAME_BITS-1];
                    w_cnt_d      = '0;
                    w_state_d    = ST_SHIFT;
                end
            end

            default: begin
                w_state_d = ST_IDLE;
            end
        endcase

        // Deselect aborts any frame in flight; nothing is committed.
        if ((r_state_q != ST_IDLE) && w_cs_rise) begin
            w_state_d     = ST_IDLE;
            w_miso_d      = 1'b0;
            w_cnt_d       = '0;
            w_frame_dv_d  = 1'b0;
            w_next_chan_d = r_next_chan_q;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            r_state_q     <= ST_IDLE;
            r_cnt_q       <= '0;
            r_rx_q        <= '0;
            r_tx_q        <= '0;
            r_miso_q      <= 1'b0;
            r_cur_chan_q  <= '0;
            r_next_chan_q <= '0;
            r_frame_dv_q  <= 1'b0;
        end else begin
            r_state_q     <= w_state_d;
            r_cnt_q       <= w_cnt_d;
            r_rx_q        <= w_rx_d;
            r_tx_q        <= w_tx_d;
            r_miso_q      <= w_miso_d;
            r_cur_chan_q  <= w_cur_chan_d;
            r_next_chan_q <= w_next_chan_d;
            r_frame_dv_q  <= w_frame_dv_d;
        end
    end

    // The oldest RX bit is shifted out without ever being inspected.
    logic w_unused_rx_msb;
    assign w_unused_rx_msb = r_rx_q[FRAME_BITS-1];

    assign o_SPI_MISO  = r_miso_q;
    assign o_Cur_Chan  = r_cur_chan_q;
    assign o_Next_Chan = r_next_chan_q;
    assign o_Frame_DV  = r_frame_dv_q;
    assign o_Busy      = (r_state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_adc_spi_responder.sv
// ============================================================================
//  Module   : tb_adc_spi_responder
//  Purpose  : Self-checking bench for adc_spi_responder. Acts as the SPI
//             master and compares returned words against a reference model
//             of the channel memory and the one-frame address pipeline.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_adc_spi_responder;

    localparam int HALF = 4;   // SCLK half period in i_Clk cycles

    logic        clk     = 1'b0;
    logic        rst_l   = 1'b0;
    logic        sclk    = 1'b0;
    logic        cs_n    = 1'b1;
    logic        mosi    = 1'b0;
    logic        wr_dv   = 1'b0;
    logic [2:0]  wr_chan = 3'd0;
    logic [11:0] wr_data = 12'd0;
    logic        miso;
    logic [2:0]  cur_chan;
    logic [2:0]  next_chan;
    logic        frame_dv;
    logic        busy;

    adc_spi_responder #(
        .DATA_WIDTH (12),
        .FRAME_BITS (16),
        .NUM_CHAN   (8)
    ) dut (
        .i_Clk       (clk),
        .i_Rst_L     (rst_l),
        .i_SPI_Clk   (sclk),
        .i_SPI_CS_n  (cs_n),
        .i_SPI_MOSI  (mosi),
        .o_SPI_MISO  (miso),
        .i_Wr_DV     (wr_dv),
        .i_Wr_Chan   (wr_chan),
        .i_Wr_Data   (wr_data),
        .o_Cur_Chan  (cur_chan),
        .o_Next_Chan (next_chan),
        .o_Frame_DV  (frame_dv),
        .o_Busy      (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;
    int dv_cnt = 0;

    // Reference model: channel memory and the committed next channel.
    logic [11:0] m_mem [8];
    logic [2:0]  m_next;

    // Every cycle with o_Frame_DV high counts, so a stretched pulse shows up.
    always @(negedge clk) begin
        if (frame_dv === 1'b1) dv_cnt++;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_mem[i] = 12'd0;
        m_next = 3'd0;
    endtask

    task automatic write_chan(input logic [2:0] ch, input logic [11:0] d);
        @(negedge clk);
        wr_dv = 1'b1; wr_chan = ch; wr_data = d;
        @(negedge clk);
        wr_dv = 1'b0;
        m_mem[ch] = d;
    endtask

    task automatic cs_start();
        @(negedge clk);
        cs_n = 1'b0;
        wait_clk(HALF);
    endtask

    task automatic cs_stop();
        @(negedge clk);
        cs_n = 1'b1;
        wait_clk(2 * HALF);
    endtask

    // Clocks n bits, MSB first; MISO is sampled at each SCLK rise. The
    // channel outputs are snapshotted just before the closing fall.
    task automatic spi_bits(input logic [15:0] w, input int n,
                            output logic [15:0] r,
                            output logic [2:0] cur_s, output logic [2:0] nxt_s);
        r = 16'd0; cur_s = 3'd0; nxt_s = 3'd0;
        for (int i = 0; i < n; i++) begin
            mosi = w[15-i];
            wait_clk(HALF);
            sclk = 1'b1;
            r[15-i] = miso;
            wait_clk(HALF);
            cur_s = cur_chan;
            nxt_s = next_chan;
            sclk = 1'b0;
        end
    endtask

    function automatic logic [15:0] mosi_word(input logic [2:0] addr);
        logic [15:0] w;
        w = 16'($urandom);   // don't-care bits randomised
        w[13:11] = addr;
        return w;
    endfunction

    task automatic check_count(input string name, input int got, input int exp);
        checks++;
        if (got !== exp)
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        else
            passed++;
    endtask

    task automatic run_frame(input string name, input logic [2:0] addr,
                             input bit start, input bit stop);
        logic [15:0] w, r, exp_word;
        logic [2:0]  cs_s, ns_s, exp_cur;
        int dv0;
        w        = mosi_word(addr);
        exp_word = {4'h0, m_mem[m_next]};
        exp_cur  = m_next;
        if (start) cs_start();
        dv0 = dv_cnt;
        spi_bits(w, 16, r, cs_s, ns_s);
        checks++;
        if (r !== exp_word) $display("FAIL %s word: got %h expected %h", name, r, exp_word);
        else passed++;
        checks++;
        if (cs_s !== exp_cur) $display("FAIL %s cur_chan: got %0d expected %0d", name, cs_s, exp_cur);
        else passed++;
        checks++;
        if (ns_s !== addr) $display("FAIL %s next_chan: got %0d expected %0d", name, ns_s, addr);
        else passed++;
        checks++;
        if ((dv_cnt - dv0) !== 1) $display("FAIL %s frame_dv cycles: got %0d expected 1", name, dv_cnt - dv0);
        else passed++;
        m_next = addr;
        if (stop) cs_stop();
    endtask

    task automatic check_idle_outputs(input string name);
        checks++;
        if ({miso, cur_chan, next_chan, frame_dv, busy} !== 9'd0)
            $display("FAIL %s outputs: got miso=%b cur=%0d next=%0d dv=%b busy=%b expected all 0",
                     name, miso, cur_chan, next_chan, frame_dv, busy);
        else
            passed++;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        rst_l = 1'b0;
        wait_clk(3);
        check_idle_outputs("reset");
        rst_l = 1'b1;
        model_reset();
        wait_clk(2);
    endtask

    task automatic test_basic();
        write_chan(3'd0, 12'hABC);
        run_frame("basic", 3'd3, 1'b1, 1'b1);
    endtask

    task automatic test_second();
        write_chan(3'd3, 12'h123);
        run_frame("second", 3'd5, 1'b1, 1'b1);
    endtask

    task automatic test_back_to_back();
        write_chan(3'd0, 12'h000);
        write_chan(3'd1, 12'h111);
        write_chan(3'd2, 12'h222);
        write_chan(3'd7, 12'hFFF);
        run_frame("b2b_prep", 3'd0, 1'b1, 1'b1);
        run_frame("b2b_0", 3'd1, 1'b1, 1'b0);
        run_frame("b2b_1", 3'd2, 1'b0, 1'b0);
        run_frame("b2b_2", 3'd7, 1'b0, 1'b0);
        run_frame("b2b_3", 3'd0, 1'b0, 1'b1);
    endtask

    task automatic test_partial();
        logic [15:0] r;
        logic [2:0]  cs_s, ns_s;
        int dv0;
        cs_start();
        dv0 = dv_cnt;
        spi_bits(mosi_word(3'd6), 8, r, cs_s, ns_s);
        cs_stop();
        check_count("partial frame_dv", dv_cnt - dv0, 0);
        checks++;
        if (next_chan !== m_next) $display("FAIL partial next_chan: got %0d expected %0d", next_chan, m_next);
        else passed++;
        checks++;
        if ({miso, busy} !== 2'b00) $display("FAIL partial miso/busy: got %b%b expected 00", miso, busy);
        else passed++;
        run_frame("after_partial", 3'd2, 1'b1, 1'b1);
    endtask

    task automatic test_wr_during_load();
        logic [15:0] r;
        logic [2:0]  cs_s, ns_s;
        int dv0;
        write_chan(3'd4, 12'h055);
        run_frame("wrload_prep", 3'd4, 1'b1, 1'b1);
        // Select falls at N0; edge detected after the 2nd posedge, LOAD state
        // after the 3rd, and the load itself happens on the 4th posedge.
        @(negedge clk);
        cs_n = 1'b0;
        wait_clk(3);
        wr_dv = 1'b1; wr_chan = 3'd4; wr_data = 12'h0AA;
        wait_clk(1);
        wr_dv = 1'b0;
        dv0 = dv_cnt;
        spi_bits(mosi_word(3'd4), 16, r, cs_s, ns_s);
        checks++;
        if (r !== 16'h0055) $display("FAIL wrload old word: got %h expected 0055", r);
        else passed++;
        check_count("wrload frame_dv", dv_cnt - dv0, 1);
        m_mem[4] = 12'h0AA;
        m_next   = 3'd4;
        run_frame("wrload_new", 3'd1, 1'b0, 1'b1);
    endtask

    task automatic test_random();
        bit active = 1'b0;
        bit stop;
        for (int i = 0; i < 10; i++) begin
            if (!active) write_chan(3'($urandom_range(0, 7)), 12'($urandom));
            stop = 1'($urandom_range(0, 1));
            run_frame("random", 3'($urandom_range(0, 7)), !active, stop);
            active = !stop;
        end
        if (active) cs_stop();
    endtask

    task automatic test_reset_mid_frame();
        logic [15:0] r;
        logic [2:0]  cs_s, ns_s;
        int dv0;
        write_chan(3'd3, 12'h321);
        cs_start();
        dv0 = dv_cnt;
        spi_bits(mosi_word(3'd5), 10, r, cs_s, ns_s);
        @(negedge clk);
        rst_l = 1'b0;
        @(negedge clk);
        check_idle_outputs("reset_mid");
        rst_l = 1'b1;
        cs_n  = 1'b1;
        wait_clk(2 * HALF);
        check_count("reset_mid frame_dv", dv_cnt - dv0, 0);
        model_reset();
        run_frame("post_reset_ch0", 3'd3, 1'b1, 1'b1);
        run_frame("post_reset_ch3", 3'd6, 1'b1, 1'b1);
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_second();
        test_back_to_back();
        test_partial();
        test_wr_during_load();
        test_random();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

`default_nettype wire
